// File: rtl/seq_mult_ctrl_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// controller state encoding, default operand widths and a sizing helper.
package mult_pkg;

    localparam int A_W_DEF = 3;
    localparam int B_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Iteration counter width; one spare bit so the last index never wraps.
    function automatic int cnt_width(input int iterations);
        return $clog2(iterations) + 1;
    endfunction

endpackage

// File: rtl/seq_mult_ctrl_add_unit.sv
// Unsigned combinational adder shared by every shift-and-add iteration.
// The carry-out is dropped because the product width cannot overflow.
module add_unit #(
    parameter int P_W = 7
) (
    input  logic [P_W-1:0] x,
    input  logic [P_W-1:0] y,
    output logic [P_W-1:0] sum
);

    assign sum = x + y;

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequential unsigned multiplier: one adder reused over A_W iterations,
// product held in a register until the next completion.
module seq_mult_ctrl
    import mult_pkg::*;
#(
    parameter  int A_W = A_W_DEF,
    parameter  int B_W = B_W_DEF,
    localparam int P_W = A_W + B_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    output logic           busy,
    output logic           done,
    output logic [P_W-1:0] product
);

    localparam int             CNT_W    = cnt_width(A_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(A_W - 1);

    state_t           state_r;
    logic [A_W-1:0]   mplier_r;
    logic [P_W-1:0]   mcand_r;
    logic [P_W-1:0]   acc_r;
    logic [CNT_W-1:0] count_r;
    logic [P_W-1:0]   product_r;
    logic [P_W-1:0]   sum_s;
    logic [P_W-1:0]   acc_next_s;

    add_unit #(
        .P_W (P_W)
    ) u_add (
        .x   (acc_r),
        .y   (mcand_r),
        .sum (sum_s)
    );

    // Partial-product accumulate: add the shifted multiplicand only when the current multiplier bit is set.
    always_comb begin
        acc_next_s = acc_r;
        if (mplier_r[0]) begin
            acc_next_s = sum_s;
        end else begin
            acc_next_s = acc_r;
        end
    end

    // Controller FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            mplier_r  <= {A_W{1'b0}};
            mcand_r   <= {P_W{1'b0}};
            acc_r     <= {P_W{1'b0}};
            count_r   <= {CNT_W{1'b0}};
            product_r <= {P_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        mplier_r <= a;
                        mcand_r  <= {{A_W{1'b0}}, b};
                        acc_r    <= {P_W{1'b0}};
                        count_r  <= {CNT_W{1'b0}};
                        state_r  <= RUN;
                    end else begin
                        state_r  <= IDLE;
                    end
                end
                RUN: begin
                    acc_r    <= acc_next_s;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    count_r  <= count_r + CNT_W'(1);
                    // The final iteration's add goes straight into the result register.
                    if (count_r == LAST_CNT) begin
                        product_r <= acc_next_s;
                        state_r   <= DONE;
                    end else begin
                        state_r   <= RUN;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy    = (state_r != IDLE);
    assign done    = (state_r == DONE);
    assign product = product_r;

endmodule
